// File: rtl/and4_sweep_if.sv
// Control/status bundle between a run controller (master) and and4_sweep_ctrl (slave).
//   start, abort, mode, vec_in : run request from the master
//   busy, done, pass, err_cnt, first_err_vec : run status back to the master
interface and4_sweep_if #(
    parameter int unsigned ERR_W = 5
);
    logic             start;
    logic             abort;
    logic             mode;
    logic [3:0]       vec_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_cnt;
    logic [3:0]       first_err_vec;

    modport master (
        output start, abort, mode, vec_in,
        input  busy, done, pass, err_cnt, first_err_vec
    );

    modport slave (
        input  start, abort, mode, vec_in,
        output busy, done, pass, err_cnt, first_err_vec
    );
endinterface

// File: rtl/and4_sweep_ctrl.sv
// Sequencer that drives operand vectors into a four-input AND datapath
// (e=a&b, f=c&d, g=a&b&c&d), holds each for HOLD_CYCLES, samples and checks
// e/f/g, and reports error count, first failing vector and pass/fail.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   ctl (slave)  : start/abort/mode/vec_in in; busy/done/pass/err_cnt/first_err_vec out
//   e, f, g      : gate outputs under test
//   a, b, c, d   : gate operands, {a,b,c,d} = current vector while busy
module and4_sweep_ctrl #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned ERR_W       = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    and4_sweep_if.slave       ctl,
    input  logic              e,
    input  logic              f,
    input  logic              g,
    output logic              a,
    output logic              b,
    output logic              c,
    output logic              d
);
    localparam int unsigned CNT_W = 8;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DRIVE  = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic [1:0]       state, state_nxt;
    logic [3:0]       vec, vec_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             mode_q, mode_nxt;
    logic [ERR_W-1:0] err_q, err_nxt;
    logic [3:0]       fev_q, fev_nxt;
    logic             pass_q, pass_nxt;
    logic             busy_q, busy_nxt;
    logic             done_q, done_nxt;
    logic [3:0]       abcd_nxt;
    logic             mismatch_c;

    // Expected gate response for the vector currently on the operands
    assign mismatch_c = ({e, f, g} != {vec[3] & vec[2], vec[1] & vec[0], &vec});

    // Next-state and next-register logic
    always_comb begin
        state_nxt = state;
        vec_nxt   = vec;
        cnt_nxt   = cnt;
        mode_nxt  = mode_q;
        err_nxt   = err_q;
        fev_nxt   = fev_q;
        pass_nxt  = pass_q;

        case (state)
            S_IDLE: begin
                // start wins over abort here; abort has no meaning in IDLE
                if (ctl.start) begin
                    vec_nxt   = ctl.mode ? ctl.vec_in : 4'd0;
                    mode_nxt  = ctl.mode;
                    err_nxt   = '0;
                    fev_nxt   = 4'd0;
                    pass_nxt  = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (ctl.abort) begin
                    pass_nxt  = 1'b0;
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        state_nxt = S_SAMPLE;
                    end
                end
            end
            S_SAMPLE: begin
                // abort suppresses this cycle's error bookkeeping
                if (ctl.abort) begin
                    pass_nxt  = 1'b0;
                    state_nxt = S_IDLE;
                end else begin
                    if (mismatch_c) begin
                        if (err_q != ERR_MAX) begin
                            err_nxt = err_q + ERR_W'(1);
                        end
                        if (err_q == '0) begin
                            fev_nxt = vec;
                        end
                    end
                    if (mode_q || (vec == 4'hF)) begin
                        pass_nxt  = (err_nxt == '0);
                        state_nxt = S_DONE;
                    end else begin
                        vec_nxt   = vec + 4'd1;
                        cnt_nxt   = '0;
                        state_nxt = S_DRIVE;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        busy_nxt = (state_nxt == S_DRIVE) || (state_nxt == S_SAMPLE);
        done_nxt = (state_nxt == S_DONE);
        abcd_nxt = busy_nxt ? vec_nxt : 4'd0;
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            vec          <= 4'd0;
            cnt          <= '0;
            mode_q       <= 1'b0;
            err_q        <= '0;
            fev_q        <= 4'd0;
            pass_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            {a, b, c, d} <= 4'd0;
        end else begin
            state        <= state_nxt;
            vec          <= vec_nxt;
            cnt          <= cnt_nxt;
            mode_q       <= mode_nxt;
            err_q        <= err_nxt;
            fev_q        <= fev_nxt;
            pass_q       <= pass_nxt;
            busy_q       <= busy_nxt;
            done_q       <= done_nxt;
            {a, b, c, d} <= abcd_nxt;
        end
    end

    assign ctl.busy          = busy_q;
    assign ctl.done          = done_q;
    assign ctl.pass          = pass_q;
    assign ctl.err_cnt       = err_q;
    assign ctl.first_err_vec = fev_q;
endmodule
